// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: default parameters, entry field
// offsets and the entry width function.
// Entry layout, LSB first: valid | killmask | src_rdy[NSRC] | src_tag[NSRC] | payload
package rs_pkg;

    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_DISP   = 2;
    localparam int unsigned DEF_ISS    = 2;
    localparam int unsigned DEF_WIN    = 8;
    localparam int unsigned DEF_NSRC   = 3;
    localparam int unsigned DEF_WK     = 4;
    localparam int unsigned DEF_TAG_W  = 7;
    localparam int unsigned DEF_SPEC_W = 4;
    localparam int unsigned DEF_PAY_W  = 64;

    localparam int unsigned OFF_VALID = 0;
    localparam int unsigned OFF_KM    = 1;

    function automatic int unsigned off_rdy(input int unsigned spec_w);
        return OFF_KM + spec_w;
    endfunction

    function automatic int unsigned off_tag(input int unsigned spec_w, input int unsigned nsrc);
        return off_rdy(spec_w) + nsrc;
    endfunction

    function automatic int unsigned off_pay(input int unsigned spec_w, input int unsigned nsrc,
                                            input int unsigned tag_w);
        return off_tag(spec_w, nsrc) + nsrc * tag_w;
    endfunction

    function automatic int unsigned entry_w(input int unsigned pay_w, input int unsigned nsrc,
                                            input int unsigned tag_w, input int unsigned spec_w);
        return off_pay(spec_w, nsrc, tag_w) + pay_w;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first selector: picks the first ISS set bits of req_i (bit 0 oldest)
// and reports each pick as a one-hot index.
//   req_i        : WIN ready flags
//   sel_valid_o  : per-port pick valid
//   sel_onehot_o : per-port one-hot index, port p at [p*WIN +: WIN]
module rs_age_select
    import rs_pkg::*;
#(
    parameter int unsigned WIN = DEF_WIN,
    parameter int unsigned ISS = DEF_ISS
) (
    input  logic [WIN-1:0]     req_i,
    output logic [ISS-1:0]     sel_valid_o,
    output logic [ISS*WIN-1:0] sel_onehot_o
);

    logic [WIN-1:0] rem;
    logic [WIN-1:0] pick;

    // Peel off the lowest set bit once per port
    always_comb begin
        rem          = req_i;
        pick         = '0;
        sel_valid_o  = '0;
        sel_onehot_o = '0;
        for (int p = 0; p < ISS; p++) begin
            pick                         = rem & (~rem + WIN'(1));
            sel_valid_o[p]               = |rem;
            sel_onehot_o[p*WIN +: WIN]   = pick;
            rem                          = rem & ~pick;
        end
    end

endmodule

// File: rtl/rs_collapse_param.sv
// Collapsing reservation station. Entries are kept age-ordered (index 0
// oldest); every cycle survivors compact toward 0 and dispatches append.
//   clk, rst               : clock, async active-high reset
//   stall_i, flush_i       : hold state / empty the RS (flush wins)
//   kill_en_i, killmask_clr_i, br_spectag_i : branch kill / resolve
//   disp_valid_i, disp_entry_i : dispatch lanes, lane 0 oldest
//   wk_valid_i, wk_tag_i   : wakeup broadcasts
//   iss_grant_i            : per-port grant of this cycle's request
//   iss_req_valid_o, iss_req_entry_o : issue requests (from registered state)
//   free_cnt_o, overflow_o : exact free entries, dispatch-drop pulse
module rs_collapse_param
    import rs_pkg::*;
#(
    parameter  int unsigned DEPTH   = DEF_DEPTH,
    parameter  int unsigned DISP    = DEF_DISP,
    parameter  int unsigned ISS     = DEF_ISS,
    parameter  int unsigned WIN     = DEF_WIN,
    parameter  int unsigned NSRC    = DEF_NSRC,
    parameter  int unsigned WK      = DEF_WK,
    parameter  int unsigned TAG_W   = DEF_TAG_W,
    parameter  int unsigned SPEC_W  = DEF_SPEC_W,
    parameter  int unsigned PAY_W   = DEF_PAY_W,
    localparam int unsigned ENTRY_W = entry_w(PAY_W, NSRC, TAG_W, SPEC_W),
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   kill_en_i,
    input  logic                   killmask_clr_i,
    input  logic [SPEC_W-1:0]      br_spectag_i,
    input  logic [DISP-1:0]        disp_valid_i,
    input  logic [DISP*ENTRY_W-1:0] disp_entry_i,
    input  logic [WK-1:0]          wk_valid_i,
    input  logic [WK*TAG_W-1:0]    wk_tag_i,
    input  logic [ISS-1:0]         iss_grant_i,
    output logic [ISS-1:0]         iss_req_valid_o,
    output logic [ISS*ENTRY_W-1:0] iss_req_entry_o,
    output logic [CNT_W-1:0]       free_cnt_o,
    output logic                   overflow_o
);

    localparam int unsigned OFF_RDY = off_rdy(SPEC_W);
    localparam int unsigned OFF_TAG = off_tag(SPEC_W, NSRC);
    localparam int unsigned NCAND   = DEPTH + DISP;

    logic [ENTRY_W-1:0] ent_q [DEPTH];
    logic [ENTRY_W-1:0] ent_d [DEPTH];
    logic [CNT_W-1:0]   free_q, free_d;
    logic               ovf_q, ovf_d;

    logic [WIN-1:0]     rdy_win;
    logic [ISS-1:0]     sel_valid;
    logic [ISS*WIN-1:0] sel_onehot;
    logic [DEPTH-1:0]   granted;
    logic [ENTRY_W-1:0] cand [NCAND];
    logic [NCAND-1:0]   live;
    int unsigned        fill;

    // Apply wakeup matches and (when no kill) killmask clear to one entry
    function automatic logic [ENTRY_W-1:0] update(input logic [ENTRY_W-1:0] e);
        logic [ENTRY_W-1:0] r;
        r = e;
        for (int k = 0; k < NSRC; k++) begin
            for (int w = 0; w < WK; w++) begin
                if (wk_valid_i[w] && (wk_tag_i[w*TAG_W +: TAG_W] == e[OFF_TAG + k*TAG_W +: TAG_W]))
                    r[OFF_RDY + k] = 1'b1;
            end
        end
        if (killmask_clr_i && !kill_en_i)
            r[OFF_KM +: SPEC_W] = e[OFF_KM +: SPEC_W] & ~br_spectag_i;
        return r;
    endfunction

    function automatic logic is_killed(input logic [ENTRY_W-1:0] e);
        return kill_en_i && (|(e[OFF_KM +: SPEC_W] & br_spectag_i));
    endfunction

    // Issue-ready flags across the window
    always_comb begin
        for (int i = 0; i < WIN; i++)
            rdy_win[i] = ent_q[i][OFF_VALID] & (&ent_q[i][OFF_RDY +: NSRC]);
    end

    rs_age_select #(.WIN(WIN), .ISS(ISS)) u_age_select (
        .req_i        (rdy_win),
        .sel_valid_o  (sel_valid),
        .sel_onehot_o (sel_onehot)
    );

    // Request mux and grant decode back to entry indices
    always_comb begin
        iss_req_valid_o = sel_valid;
        iss_req_entry_o = '0;
        granted         = '0;
        for (int p = 0; p < ISS; p++) begin
            for (int i = 0; i < WIN; i++) begin
                if (sel_onehot[p*WIN + i]) begin
                    iss_req_entry_o[p*ENTRY_W +: ENTRY_W] = iss_req_entry_o[p*ENTRY_W +: ENTRY_W] | ent_q[i];
                    if (iss_grant_i[p])
                        granted[i] = 1'b1;
                end
            end
        end
    end

    // Candidates in age order: residents then dispatch lanes
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = update(ent_q[i]);
            live[i] = ent_q[i][OFF_VALID] & ~granted[i] & ~is_killed(ent_q[i]);
        end
        for (int l = 0; l < DISP; l++) begin
            cand[DEPTH + l]            = update(disp_entry_i[l*ENTRY_W +: ENTRY_W]);
            cand[DEPTH + l][OFF_VALID] = 1'b1;
            live[DEPTH + l]            = disp_valid_i[l] & ~is_killed(disp_entry_i[l*ENTRY_W +: ENTRY_W]);
        end
    end

    // Compaction plus stall/flush override
    always_comb begin
        fill  = 0;
        ovf_d = 1'b0;
        for (int j = 0; j < DEPTH; j++)
            ent_d[j] = '0;
        for (int n = 0; n < NCAND; n++) begin
            if (live[n]) begin
                if (fill < DEPTH) begin
                    for (int j = 0; j < DEPTH; j++)
                        if (fill == j) ent_d[j] = cand[n];
                    fill = fill + 1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        free_d = CNT_W'(DEPTH - fill);

        if (flush_i) begin
            for (int j = 0; j < DEPTH; j++)
                ent_d[j] = '0;
            free_d = CNT_W'(DEPTH);
            ovf_d  = 1'b0;
        end else if (stall_i) begin
            ent_d  = ent_q;
            free_d = free_q;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                ent_q[j] <= '0;
            free_q <= CNT_W'(DEPTH);
            ovf_q  <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            free_q <= free_d;
            ovf_q  <= ovf_d;
        end
    end

    assign free_cnt_o = free_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_rs_collapse_param.sv
// Directed self-checking bench for rs_collapse_param: expected outputs are
// queued as stimulus is applied and compared after the following edge.
module tb_rs_collapse_param;
    import rs_pkg::*;

    localparam int unsigned EW    = entry_w(DEF_PAY_W, DEF_NSRC, DEF_TAG_W, DEF_SPEC_W);
    localparam int unsigned O_RDY = off_rdy(DEF_SPEC_W);
    localparam int unsigned O_TAG = off_tag(DEF_SPEC_W, DEF_NSRC);
    localparam int unsigned O_PAY = off_pay(DEF_SPEC_W, DEF_NSRC, DEF_TAG_W);
    localparam int unsigned CW    = $clog2(DEF_DEPTH + 1);

    logic          clk, rst, stall_i, flush_i, kill_en_i, killmask_clr_i;
    logic [3:0]    br_spectag_i;
    logic [1:0]    disp_valid_i;
    logic [2*EW-1:0] disp_entry_i;
    logic [3:0]    wk_valid_i;
    logic [27:0]   wk_tag_i;
    logic [1:0]    iss_grant_i;
    logic [1:0]    iss_req_valid_o;
    logic [2*EW-1:0] iss_req_entry_o;
    logic [CW-1:0] free_cnt_o;
    logic          overflow_o;

    logic [63:0]   p0, p1;
    logic [3:0]    km0;

    int checks = 0;
    int errors = 0;
    string        qn[$];
    logic [127:0] qv[$];

    rs_collapse_param dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .kill_en_i       (kill_en_i),
        .killmask_clr_i  (killmask_clr_i),
        .br_spectag_i    (br_spectag_i),
        .disp_valid_i    (disp_valid_i),
        .disp_entry_i    (disp_entry_i),
        .wk_valid_i      (wk_valid_i),
        .wk_tag_i        (wk_tag_i),
        .iss_grant_i     (iss_grant_i),
        .iss_req_valid_o (iss_req_valid_o),
        .iss_req_entry_o (iss_req_entry_o),
        .free_cnt_o      (free_cnt_o),
        .overflow_o      (overflow_o)
    );

    assign p0  = iss_req_entry_o[O_PAY +: 64];
    assign p1  = iss_req_entry_o[EW + O_PAY +: 64];
    assign km0 = iss_req_entry_o[OFF_KM +: 4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic [63:0] pay, input logic [6:0] tag,
                                         input logic rdy, input logic [3:0] km);
        logic [EW-1:0] e;
        e              = '0;
        e[OFF_VALID]   = 1'b1;
        e[OFF_KM +: 4] = km;
        for (int k = 0; k < 3; k++) begin
            e[O_RDY + k]         = rdy;
            e[O_TAG + k*7 +: 7]  = tag;
        end
        e[O_PAY +: 64] = pay;
        return e;
    endfunction

    task automatic idle();
        stall_i = 0; flush_i = 0; kill_en_i = 0; killmask_clr_i = 0;
        br_spectag_i = '0; disp_valid_i = '0; disp_entry_i = '0;
        wk_valid_i = '0; wk_tag_i = '0; iss_grant_i = '0;
    endtask

    task automatic disp2(input logic [EW-1:0] a, input logic [EW-1:0] b);
        disp_valid_i = 2'b11;
        disp_entry_i = {b, a};
    endtask

    task automatic disp1(input logic [EW-1:0] a);
        disp_valid_i = 2'b01;
        disp_entry_i = {{EW{1'b0}}, a};
    endtask

    task automatic expect_v(input string n, input logic [127:0] v);
        qn.push_back(n);
        qv.push_back(v);
    endtask

    task automatic check_v(input logic [127:0] obs);
        string        n;
        logic [127:0] v;
        checks++;
        if (qn.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h required=none", obs);
            return;
        end
        n = qn.pop_front();
        v = qv.pop_front();
        assert (obs === v) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", n, obs, v);
        end
    endtask

    task automatic exp_std(input string n, input int fr, input logic ovf, input logic [1:0] rv,
                           input logic [63:0] e0, input logic [63:0] e1);
        expect_v({n, "_free"}, 128'(fr));
        expect_v({n, "_ovf"},  128'(ovf));
        expect_v({n, "_rv"},   128'(rv));
        expect_v({n, "_p0"},   128'(e0));
        expect_v({n, "_p1"},   128'(e1));
    endtask

    task automatic chk_std();
        check_v(128'(free_cnt_o));
        check_v(128'(overflow_o));
        check_v(128'(iss_req_valid_o));
        check_v(128'(p0));
        check_v(128'(p1));
    endtask

    // Queue expectations, clock once with the driven inputs, then compare
    task automatic run(input string n, input int fr, input logic ovf, input logic [1:0] rv,
                       input logic [63:0] e0, input logic [63:0] e1);
        exp_std(n, fr, ovf, rv, e0, e1);
        @(posedge clk);
        #1;
        idle();
        chk_std();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_std("reset", 16, 0, 2'b00, 64'h0, 64'h0);
        expect_v("reset_entry", 128'(0));
        chk_std();
        check_v(128'(|iss_req_entry_o));
        rst = 1'b0;

        // Fill two per cycle, then one more overflows
        for (int c = 0; c < 8; c++) begin
            disp2(mk(64'hA000 + 64'(2*c), 7'h0, 1'b1, 4'h0), mk(64'hA001 + 64'(2*c), 7'h0, 1'b1, 4'h0));
            run("fill", 14 - 2*c, 0, 2'b11, 64'hA000, 64'hA001);
        end
        disp1(mk(64'hA010, 7'h0, 1'b1, 4'h0));
        run("ovf", 0, 1, 2'b11, 64'hA000, 64'hA001);
        run("ovf_clear", 0, 0, 2'b11, 64'hA000, 64'hA001);
        flush_i = 1;
        run("flush", 16, 0, 2'b00, 64'h0, 64'h0);

        // Collapse: entries 1 and 3 ready, grant both
        disp2(mk(64'h10, 7'h40, 1'b0, 4'h0), mk(64'h11, 7'h41, 1'b1, 4'h0));
        run("col_d0", 14, 0, 2'b01, 64'h11, 64'h0);
        disp2(mk(64'h12, 7'h42, 1'b0, 4'h0), mk(64'h13, 7'h43, 1'b1, 4'h0));
        run("col_d1", 12, 0, 2'b11, 64'h11, 64'h13);
        disp2(mk(64'h14, 7'h44, 1'b0, 4'h0), mk(64'h15, 7'h45, 1'b0, 4'h0));
        run("col_d2", 10, 0, 2'b11, 64'h11, 64'h13);
        iss_grant_i = 2'b11;
        run("col_grant", 12, 0, 2'b00, 64'h0, 64'h0);
        wk_valid_i = 4'b0011;
        wk_tag_i[0 +: 7] = 7'h45;
        wk_tag_i[7 +: 7] = 7'h42;
        run("col_order", 12, 0, 2'b11, 64'h12, 64'h15);
        iss_grant_i = 2'b01;
        run("col_g1", 13, 0, 2'b01, 64'h15, 64'h0);
        flush_i = 1;
        run("flush2", 16, 0, 2'b00, 64'h0, 64'h0);

        // Wakeup in the dispatch cycle
        disp1(mk(64'h37, 7'h25, 1'b0, 4'h0));
        wk_valid_i = 4'b0100;
        wk_tag_i[14 +: 7] = 7'h25;
        run("wake_disp", 15, 0, 2'b01, 64'h37, 64'h0);
        flush_i = 1;
        run("flush3", 16, 0, 2'b00, 64'h0, 64'h0);

        // Kill beats clear; a dispatched entry is killed too
        disp2(mk(64'hA1, 7'h0, 1'b1, 4'b0001), mk(64'hB2, 7'h0, 1'b1, 4'b0010));
        run("kill_d", 14, 0, 2'b11, 64'hA1, 64'hB2);
        disp1(mk(64'hC3, 7'h0, 1'b1, 4'b0001));
        kill_en_i = 1; killmask_clr_i = 1; br_spectag_i = 4'b0001;
        run("kill", 15, 0, 2'b01, 64'hB2, 64'h0);
        expect_v("kill_km", 128'(4'b0010));
        check_v(128'(km0));
        killmask_clr_i = 1; br_spectag_i = 4'b0010;
        run("clr", 15, 0, 2'b01, 64'hB2, 64'h0);
        expect_v("clr_km", 128'(4'b0000));
        check_v(128'(km0));
        flush_i = 1;
        run("flush4", 16, 0, 2'b00, 64'h0, 64'h0);

        // Window: ready entry at index 8 is invisible until older ones leave
        for (int c = 0; c < 4; c++) begin
            disp2(mk(64'h20 + 64'(2*c), 7'h50 + 7'(2*c), 1'b0, 4'h0),
                  mk(64'h21 + 64'(2*c), 7'h51 + 7'(2*c), 1'b0, 4'h0));
            run("win_d", 14 - 2*c, 0, 2'b00, 64'h0, 64'h0);
        end
        disp1(mk(64'h99, 7'h0, 1'b1, 4'h0));
        run("win_only", 7, 0, 2'b00, 64'h0, 64'h0);
        wk_valid_i = 4'b0011;
        wk_tag_i[0 +: 7] = 7'h50;
        wk_tag_i[7 +: 7] = 7'h51;
        run("win_wake", 7, 0, 2'b11, 64'h20, 64'h21);
        iss_grant_i = 2'b11;
        run("win_issue", 9, 0, 2'b01, 64'h99, 64'h0);

        // Stall ignores everything; flush overrides stall
        stall_i = 1; iss_grant_i = 2'b11;
        disp1(mk(64'h77, 7'h0, 1'b1, 4'h0));
        wk_valid_i = 4'b0001;
        wk_tag_i[0 +: 7] = 7'h52;
        run("stall", 9, 0, 2'b01, 64'h99, 64'h0);
        stall_i = 1; flush_i = 1; iss_grant_i = 2'b01;
        run("stall_flush", 16, 0, 2'b00, 64'h0, 64'h0);

        // Reset mid-operation discards in-flight dispatch and grant
        disp1(mk(64'h44, 7'h0, 1'b1, 4'h0));
        run("pre_rst", 15, 0, 2'b01, 64'h44, 64'h0);
        disp2(mk(64'h45, 7'h0, 1'b1, 4'h0), mk(64'h46, 7'h0, 1'b1, 4'h0));
        iss_grant_i = 2'b01;
        rst = 1'b1;
        run("rst_mid", 16, 0, 2'b00, 64'h0, 64'h0);
        rst = 1'b0;
        run("post_rst", 16, 0, 2'b00, 64'h0, 64'h0);
        disp1(mk(64'h55, 7'h0, 1'b1, 4'h0));
        run("post_rst_disp", 15, 0, 2'b01, 64'h55, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
